// File: rtl/i2c_codec_cmd_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master for SSM2603 writes.
// Optional retry-on-error via `define I2C_ARB_RETRY_EN.
module i2c_codec_cmd_arbiter #(
  parameter int         NUM_REQ     = 2,
  parameter logic [7:0] DEV_ADDR    = 8'h34,
  parameter int         MAX_RETRIES = 2
) (
  input  logic                 CLK_I2C,
  input  logic                 RESET,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [7*NUM_REQ-1:0] req_reg,
  input  logic [9*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   rsp_done,
  output logic [NUM_REQ-1:0]   rsp_err,
  output logic                 busy,
  output logic [7:0]           i2c_out,
  output logic                 i2c_start,
  output logic                 i2c_end,
  output logic                 i2c_write,
  output logic                 i2c_read,
  input  logic                 i2c_ready,
  input  logic                 i2c_error
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_HOLD, S_WAIT, S_RESP
  } state_t;

  state_t             r_state, w_state;
  logic [IW-1:0]      r_ptr, w_ptr;
  logic [2:0]         r_step, w_step;
  logic               r_err, w_err;
  logic [6:0]         r_reg, w_reg;
  logic [8:0]         r_data, w_data;
  logic               r_busy, w_busy;
  logic [NUM_REQ-1:0] r_rdy, w_rdy;
  logic [NUM_REQ-1:0] r_done, w_done;
  logic [NUM_REQ-1:0] r_errp, w_errp;
  logic [7:0]         r_out, w_out;
  logic               r_start, w_start;
  logic               r_end, w_end;
  logic               r_write, w_write;
  logic               w_any;
  logic [IW-1:0]      w_sel;
  logic               w_retry;

  // Scan downward so the nearest valid index after the pointer wins.
  always_comb begin
    logic [IW-1:0] idx;
    w_any = 1'b0;
    w_sel = '0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(r_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        w_any = 1'b1;
        w_sel = idx;
      end
    end
  end

`ifdef I2C_ARB_RETRY_EN
  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
  logic [RW-1:0] r_retries, w_retries;

  assign w_retry = r_err && (r_retries < RW'(MAX_RETRIES));

  always_comb begin
    w_retries = r_retries;
    if (r_state == S_IDLE)
      w_retries = '0;
    else if (r_state == S_RESP && w_retry)
      w_retries = r_retries + RW'(1);
  end

  always_ff @(posedge CLK_I2C) begin
    if (RESET) r_retries <= '0;
    else       r_retries <= w_retries;
  end
`else
  assign w_retry = 1'b0;
`endif

  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_step  = r_step;
    w_err   = r_err;
    w_reg   = r_reg;
    w_data  = r_data;
    w_busy  = r_busy;
    w_rdy   = '0;
    w_done  = '0;
    w_errp  = '0;
    w_out   = '0;
    w_start = 1'b0;
    w_end   = 1'b0;
    w_write = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i2c_ready && w_any) begin
          w_rdy   = NUM_REQ'(1) << w_sel;
          w_ptr   = w_sel;
          w_reg   = req_reg[int'(w_sel)*7 +: 7];
          w_data  = req_data[int'(w_sel)*9 +: 9];
          w_step  = 3'd0;
          w_err   = 1'b0;
          w_busy  = 1'b1;
          w_state = S_CMD;
        end
      end
      S_CMD: begin
        w_state = S_HOLD;
        unique case (r_step)
          3'd0: w_start = 1'b1;
          3'd1: begin
            w_write = 1'b1;
            w_out   = DEV_ADDR;
          end
          3'd2: begin
            w_write = 1'b1;
            w_out   = {r_reg, r_data[8]};
          end
          3'd3: begin
            w_write = 1'b1;
            w_out   = r_data[7:0];
          end
          default: w_end = 1'b1;
        endcase
      end
      S_HOLD: w_state = S_WAIT;
      S_WAIT: begin
        if (i2c_ready) begin
          if (r_step == 3'd4) begin
            w_state = S_RESP;
          end else if (r_step != 3'd0 && i2c_error) begin
            w_err   = 1'b1;
            w_step  = 3'd4;
            w_state = S_CMD;
          end else begin
            w_step  = r_step + 3'd1;
            w_state = S_CMD;
          end
        end
      end
      S_RESP: begin
        if (w_retry) begin
          w_err   = 1'b0;
          w_step  = 3'd0;
          w_state = S_CMD;
        end else begin
          w_busy  = 1'b0;
          w_state = S_IDLE;
          if (r_err) w_errp = NUM_REQ'(1) << r_ptr;
          else       w_done = NUM_REQ'(1) << r_ptr;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I2C) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_ptr   <= IW'(NUM_REQ - 1);
      r_step  <= '0;
      r_err   <= 1'b0;
      r_reg   <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_rdy   <= '0;
      r_done  <= '0;
      r_errp  <= '0;
      r_out   <= '0;
      r_start <= 1'b0;
      r_end   <= 1'b0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_step  <= w_step;
      r_err   <= w_err;
      r_reg   <= w_reg;
      r_data  <= w_data;
      r_busy  <= w_busy;
      r_rdy   <= w_rdy;
      r_done  <= w_done;
      r_errp  <= w_errp;
      r_out   <= w_out;
      r_start <= w_start;
      r_end   <= w_end;
      r_write <= w_write;
    end
  end

  assign req_ready = r_rdy;
  assign rsp_done  = r_done;
  assign rsp_err   = r_errp;
  assign busy      = r_busy;
  assign i2c_out   = r_out;
  assign i2c_start = r_start;
  assign i2c_end   = r_end;
  assign i2c_write = r_write;
  assign i2c_read  = 1'b0;

endmodule

// File: tb/tb_i2c_codec_cmd_arbiter.sv
// Bench for i2c_codec_cmd_arbiter: table vectors, random writes, corner sequences.
// Master latency/error behaviour is modelled below; I2C_ARB_RETRY_EN aware.
module tb_i2c_codec_cmd_arbiter;

  localparam int NR   = 2;
  localparam int MAXR = 2;
`ifdef I2C_ARB_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          RESET;
  logic [NR-1:0] req_valid, req_ready, rsp_done, rsp_err;
  logic [7*NR-1:0] req_reg;
  logic [9*NR-1:0] req_data;
  logic          busy, i2c_start, i2c_end, i2c_write, i2c_read;
  logic [7:0]    i2c_out;
  logic          i2c_ready, i2c_error;

  i2c_codec_cmd_arbiter #(
    .NUM_REQ(NR), .DEV_ADDR(8'h34), .MAX_RETRIES(MAXR)
  ) dut (
    .CLK_I2C(clk), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data),
    .rsp_done(rsp_done), .rsp_err(rsp_err), .busy(busy),
    .i2c_out(i2c_out), .i2c_start(i2c_start), .i2c_end(i2c_end),
    .i2c_write(i2c_write), .i2c_read(i2c_read),
    .i2c_ready(i2c_ready), .i2c_error(i2c_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [NR-1:0] d;
    logic [NR-1:0] e;
    logic          b;
  } rsp_t;

  logic [10:0] log_q[$];
  logic [10:0] exp_q[$];
  rsp_t        rsp_q[$];
  int          gnt_q[$];

  // Master model configuration (written by the stimulus process)
  int lat_cfg = 3, errw_cfg = 0, fails_cfg = 0, txn_id = 0;
  bit junk_cfg = 0;

  int   mcnt = 0, attempt = 0, wcnt = 0, seen_id = -1, prot_err = 0;
  logic merr = 1'b0;

  assign i2c_ready = (mcnt == 0);
  assign i2c_error = merr & i2c_ready;

  always @(posedge clk) begin
    if (RESET) begin
      mcnt <= 0;
      merr <= 1'b0;
    end else if (i2c_start | i2c_end | i2c_write) begin
      if (mcnt != 0) prot_err <= prot_err + 1;
      log_q.push_back({i2c_start, i2c_end, i2c_write, i2c_out});
      mcnt <= lat_cfg;
      if (i2c_start) begin
        if (seen_id != txn_id) begin
          attempt <= 1;
          seen_id <= txn_id;
        end else attempt <= attempt + 1;
        wcnt <= 0;
        merr <= junk_cfg;
      end else if (i2c_write) begin
        wcnt <= wcnt + 1;
        merr <= (wcnt + 1 == errw_cfg) && (attempt <= fails_cfg);
      end else merr <= junk_cfg;
    end else if (mcnt != 0) mcnt <= mcnt - 1;
  end

  always @(negedge clk) begin
    if (!RESET) begin
      if (req_ready != '0) begin
        checks++;
        if ($countones(req_ready) != 1) begin
          errors++;
          $display("FAIL grant_onehot got=%b", req_ready);
        end
        for (int i = 0; i < NR; i++)
          if (req_ready[i]) gnt_q.push_back(i);
      end
      if ((rsp_done | rsp_err) != '0)
        rsp_q.push_back('{rsp_done, rsp_err, busy});
      if (i2c_start | i2c_end | i2c_write) begin
        checks++;
        if ((int'(i2c_start) + int'(i2c_end) + int'(i2c_write)) != 1 ||
            (!i2c_write && i2c_out != 8'h00)) begin
          errors++;
          $display("FAIL cmd_pulse got s=%b e=%b w=%b out=%h",
                   i2c_start, i2c_end, i2c_write, i2c_out);
        end
      end
    end
  end

  // Expected command stream from the write/retry rules.
  bit exp_err_model;
  function automatic void build_exp(input logic [6:0] rg,
                                    input logic [8:0] dt,
                                    input int ew, input int fl);
    logic [7:0] b [3];
    int amax;
    bit fail;
    b[0] = 8'h34;
    b[1] = {rg, dt[8]};
    b[2] = dt[7:0];
    amax = RETRY ? MAXR + 1 : 1;
    exp_q.delete();
    fail = 1'b0;
    for (int a = 1; a <= amax; a++) begin
      fail = 1'b0;
      exp_q.push_back(11'h400);
      for (int k = 1; k <= 3; k++) begin
        exp_q.push_back({3'b001, b[k-1]});
        if (k == ew && a <= fl) begin
          fail = 1'b1;
          break;
        end
      end
      exp_q.push_back(11'h200);
      if (!fail) break;
    end
    exp_err_model = fail;
  endfunction

  int last_base;

  task automatic run_txn(input int idx, input logic [6:0] rg,
                         input logic [8:0] dt, input int ew,
                         input int fl, input int lt, input bit jk,
                         input bit exp_err);
    int base, rb, gb, n;
    rsp_t r;
    logic [NR-1:0] ed, ee;
    @(negedge clk);
    errw_cfg = ew; fails_cfg = fl; lat_cfg = lt; junk_cfg = jk;
    txn_id++;
    base = log_q.size(); rb = rsp_q.size(); gb = gnt_q.size();
    last_base = base;
    req_reg[7*idx +: 7]  = rg;
    req_data[9*idx +: 9] = dt;
    req_valid[idx] = 1'b1;
    n = 0;
    while (gnt_q.size() == gb && n < 200) begin
      @(negedge clk); n++;
    end
    req_valid[idx] = 1'b0;
    checks++;
    if (gnt_q.size() == gb) begin
      errors++;
      $display("FAIL grant_timeout req=%0d got=none", idx);
    end else if (gnt_q[gb] != idx || !busy) begin
      errors++;
      $display("FAIL grant got=%0d busy=%b want=%0d busy=1",
               gnt_q[gb], busy, idx);
    end
    n = 0;
    while (rsp_q.size() == rb && n < 3000) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_q.size() != rb + 1) begin
      errors++;
      $display("FAIL rsp_count got=%0d want=1", rsp_q.size() - rb);
    end else begin
      r  = rsp_q[rb];
      ed = exp_err ? '0 : NR'(1) << idx;
      ee = exp_err ? NR'(1) << idx : '0;
      checks++;
      if (r.d != ed || r.e != ee || r.b) begin
        errors++;
        $display("FAIL rsp got done=%b err=%b busy=%b want done=%b err=%b busy=0",
                 r.d, r.e, r.b, ed, ee);
      end
    end
    checks++;
    if (log_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL cmd_len got=%0d want=%0d",
               log_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
      checks++;
      if (log_q[base+i] != exp_q[i]) begin
        errors++;
        $display("FAIL cmd[%0d] got=%h want=%h", i, log_q[base+i], exp_q[i]);
      end
    end
  endtask

  int arb_g0, arb_r0, arb_l0;
  task automatic arb_seq(input int ng);
    int n;
    @(negedge clk);
    errw_cfg = 0; fails_cfg = 0; lat_cfg = 3; junk_cfg = 0;
    txn_id++;
    arb_g0 = gnt_q.size(); arb_r0 = rsp_q.size(); arb_l0 = log_q.size();
    req_reg   = {7'd5, 7'd4};
    req_data  = {9'h1AB, 9'h022};
    req_valid = '1;
    n = 0;
    while (gnt_q.size() < arb_g0 + ng && n < 3000) begin
      @(negedge clk); n++;
    end
    req_valid = '0;
    n = 0;
    while (rsp_q.size() < arb_r0 + ng && n < 3000) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_q.size() != arb_r0 + ng || gnt_q.size() != arb_g0 + ng) begin
      errors++;
      $display("FAIL arb_count got grants=%0d rsps=%0d want=%0d",
               gnt_q.size() - arb_g0, rsp_q.size() - arb_r0, ng);
    end
    for (int i = 0; i < ng; i++) begin
      if (arb_g0 + i < gnt_q.size() && arb_r0 + i < rsp_q.size()) begin
        checks++;
        if (gnt_q[arb_g0+i] != i % 2 ||
            rsp_q[arb_r0+i].d != NR'(1) << (i % 2) ||
            rsp_q[arb_r0+i].e != '0) begin
          errors++;
          $display("FAIL arb[%0d] got grant=%0d done=%b err=%b want grant=%0d",
                   i, gnt_q[arb_g0+i], rsp_q[arb_r0+i].d,
                   rsp_q[arb_r0+i].e, i % 2);
        end
      end
    end
  endtask

  task automatic check_all_zero(input string nm);
    logic [31:0] v;
    v = {req_ready, rsp_done, rsp_err, busy, i2c_out,
         i2c_start, i2c_end, i2c_write, i2c_read};
    checks++;
    if (v != '0) begin
      errors++;
      $display("FAIL %s got=%h want=0", nm, v);
    end
  endtask

  typedef struct {
    int         idx;
    logic [6:0] rg;
    logic [8:0] dt;
    int         ew;
    int         fl;
    int         lat;
    bit         exp_err;
  } vec_t;

  vec_t vt[6];

  initial begin
    int base, n;
    logic [6:0] rg;
    logic [8:0] dt;
    vt[0] = '{0, 7'd6,  9'h070, 0, 0, 10, 1'b0};
    vt[1] = '{1, 7'd0,  9'h197, 0, 0, 10, 1'b0};
    vt[2] = '{0, 7'd6,  9'h070, 2, 1, 4,  !RETRY};
    vt[3] = '{0, 7'd9,  9'h0FF, 1, 3, 2,  1'b1};
    vt[4] = '{1, 7'h7F, 9'h100, 1, 1, 1,  !RETRY};
    vt[5] = '{1, 7'd4,  9'h055, 3, 0, 5,  1'b0};

    RESET = 1'b1; req_valid = '0; req_reg = '0; req_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    RESET = 1'b0;

    for (int i = 0; i < 6; i++) begin
      build_exp(vt[i].rg, vt[i].dt, vt[i].ew, vt[i].fl);
      run_txn(vt[i].idx, vt[i].rg, vt[i].dt, vt[i].ew, vt[i].fl,
              vt[i].lat, 1'b0, vt[i].exp_err);
      if (i == 0) begin
        checks++;
        if (log_q.size() < last_base + 5 ||
            log_q[last_base+1][7:0] != 8'h34 ||
            log_q[last_base+2][7:0] != 8'h0C ||
            log_q[last_base+3][7:0] != 8'h70) begin
          errors++;
          $display("FAIL first_bytes got=%h %h %h want=34 0c 70",
                   log_q[last_base+1][7:0], log_q[last_base+2][7:0],
                   log_q[last_base+3][7:0]);
        end
      end
    end

    for (int i = 0; i < 20; i++) begin
      int idx, ew, fl, lt;
      bit jk;
      idx = $urandom_range(0, NR - 1);
      rg  = 7'($urandom);
      dt  = 9'($urandom);
      ew  = $urandom_range(0, 3);
      fl  = $urandom_range(0, 3);
      lt  = $urandom_range(1, 12);
      jk  = 1'($urandom_range(0, 1));
      build_exp(rg, dt, ew, fl);
      run_txn(idx, rg, dt, ew, fl, lt, jk, exp_err_model);
    end

    RESET = 1'b1;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    arb_seq(4);

    @(negedge clk);
    errw_cfg = 0; fails_cfg = 0; lat_cfg = 10; junk_cfg = 0;
    txn_id++;
    base = log_q.size();
    req_reg[13:7] = 7'd2; req_data[17:9] = 9'h011;
    req_valid[1] = 1'b1;
    n = 0;
    while (log_q.size() < base + 3 && n < 500) begin
      @(negedge clk); n++;
      if (req_ready[1]) req_valid[1] = 1'b0;
    end
    req_valid = '0;
    repeat (2) @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    RESET = 1'b0;
    checks++;
    if (log_q.size() != base + 3) begin
      errors++;
      $display("FAIL mid_reset_cmds got=%0d want=3", log_q.size() - base);
    end
    arb_seq(2);
    checks++;
    if (arb_l0 >= log_q.size() || log_q[arb_l0] != 11'h400) begin
      errors++;
      $display("FAIL post_reset_start got=%h want=400", log_q[arb_l0]);
    end

    checks++;
    if (prot_err != 0) begin
      errors++;
      $display("FAIL cmd_while_busy got=%0d want=0", prot_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_codec_cmd_arbiter.md
Name: i2c_codec_cmd_arbiter

Overview:
- Shares one byte-level I2C master between NUM_REQ requesters, for example the codec bringup sequencer and a runtime volume/mute controller.
- Each requester submits one SSM2603 register write: 7-bit register address and 9-bit data.
- The arbiter grants requesters round-robin and expands each grant into the master command sequence START, WRITE dev, WRITE reg, WRITE data, STOP.
- It returns a done or err pulse to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DEV_ADDR, 8'h34, device write-address byte, sent as-is.
- MAX_RETRIES, 2, extra attempts after an error (used only with I2C_ARB_RETRY_EN).

Ports:
- CLK_I2C  in  1  I2C-domain clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending; payload held stable until accepted.
- req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse.
- req_reg  in  7*NUM_REQ  register address; slot i at [7i+6:7i].
- req_data  in  9*NUM_REQ  register data; slot i at [9i+8:9i].
- rsp_done  out  NUM_REQ  1-cycle pulse: transaction completed without error.
- rsp_err  out  NUM_REQ  1-cycle pulse: transaction failed.
- busy  out  1  high from grant through the response pulse.
- i2c_out  out  8  byte for a WRITE command.
- i2c_start  out  1  START command pulse.
- i2c_end  out  1  STOP command pulse.
- i2c_write  out  1  WRITE command pulse.
- i2c_read  out  1  tied 0.
- i2c_ready  in  1  master idle and able to take a command.
- i2c_error  in  1  NACK/error for the last byte; valid while i2c_ready=1.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer set so requester 0 has highest priority; retry count 0.
- All outputs are registered.

Master handshake:
- A command is a 1-cycle pulse of exactly one of i2c_start, i2c_end or i2c_write. i2c_out is valid with i2c_write and is 0 otherwise.
- Commands are issued only while i2c_ready=1.
- After a pulse, i2c_ready is ignored for one cycle (HOLD). The master drops ready within that cycle.
- The arbiter then waits in WAIT for i2c_ready=1.

FSM:
- IDLE
  - When i2c_ready=1 and any req_valid is set, grant the first valid index after the pointer (cyclic).
  - Pulse req_ready[g], latch reg/data, set pointer=g, step=0, retries=0, busy=1.
  - Go to CMD on the next cycle.
- CMD: issue the command for the current step:
  - step 0: START.
  - step 1: WRITE DEV_ADDR.
  - step 2: WRITE {reg[6:0], data[8]}.
  - step 3: WRITE data[7:0].
  - step 4: STOP.
  - Then go to HOLD.
- HOLD: wait 1 cycle, then go to WAIT.
- WAIT: when i2c_ready=1:
  - After steps 1-3 with i2c_error=1: set the error flag, jump to step 4, go to CMD.
  - After steps 0-3 with no error: step+1, go to CMD.
  - After step 4: go to RESP.
- RESP:
  - Error flag clear: pulse rsp_done[g].
  - Error flag set: pulse rsp_err[g] (retry rules below).
  - busy falls the same cycle as the pulse; return to IDLE.

Rules:
- i2c_error after START or STOP is ignored.
- Minimum command spacing is 3 cycles: CMD, HOLD, WAIT.
- A new grant is possible one cycle after RESP.
- req_valid dropping after acceptance has no effect.
- Only one transaction is in flight; other requesters wait with req_ready=0.
- Simultaneous requests: the lowest index at or after pointer+1 wins. A requester that just finished has lowest priority.
- RESET asserted mid-transaction: immediate return to reset values next cycle, with no STOP issued. The system resets the I2C master together with the arbiter.

Optional Feature:
- Macro I2C_ARB_RETRY_EN.
- Defined:
  - At RESP with the error flag set and retries < MAX_RETRIES: no response pulse.
  - retries+1, clear the error flag, step=0, back to CMD. The same payload is resent, with no re-grant.
  - Once retries reaches MAX_RETRIES, the next failure pulses rsp_err.
  - busy stays high across retries.
- Not defined: the first failure pulses rsp_err. The retry counter logic is absent.

Test Plan:
1. After reset, req0 reg=6, data=9'h070, master model with 10-cycle ready-low per command -> START, 0x34, 0x0C, 0x70, STOP in order; rsp_done[0] pulses once; busy falls with it.
2. req1 reg=0, data=9'h197 -> write bytes 0x34, 0x01, 0x97; rsp_done[1] pulses.
3. req0 and req1 valid on the same cycle after reset -> req0 granted first, then req1. req0 re-asserts during req1's transaction -> req0 granted next. With req0 held valid continuously and req1 re-asserted, grants alternate 0,1,0,1.
4. Master returns i2c_error after the reg byte, macro off -> no data-byte WRITE; STOP issued; rsp_err[0] pulses; rsp_done stays 0.
5. Macro on, MAX_RETRIES=2, persistent error on the dev byte -> 3 attempts, each START, 0x34, STOP, then a single rsp_err pulse. Error only on the first attempt -> second attempt completes; rsp_done pulses.
6. RESET pulsed while in WAIT after the reg byte -> next cycle all outputs 0 and busy=0. A subsequent request begins with START; priority is back to requester 0.
